// File: rtl/glip_channel_arbiter_if.sv
// ============================================================================
// Module      : glip_channel_arbiter_if
// Description : Channel-side and backend-side handshake bundle of the GLIP
//               channel arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface glip_channel_arbiter_if #(
    parameter int WORD_WIDTH = 16,
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 8
);
    logic [NUM_CH*WORD_WIDTH-1:0] ch_data;
    logic [NUM_CH-1:0]            ch_valid;
    logic [NUM_CH-1:0]            ch_ready;
    logic [NUM_CH*CNT_W-1:0]      ch_avail;
    logic [WORD_WIDTH-1:0]        out_data;
    logic                         out_valid;
    logic                         out_ready;
    logic [NUM_CH-1:0]            grant;
    logic                         busy;

    modport master (
        input  ch_data, ch_valid, ch_avail, out_ready,
        output ch_ready, out_data, out_valid, grant, busy
    );

    modport slave (
        output ch_data, ch_valid, ch_avail, out_ready,
        input  ch_ready, out_data, out_valid, grant, busy
    );
endinterface

`default_nettype wire

// File: rtl/glip_channel_arbiter.sv
// ============================================================================
// Module      : glip_channel_arbiter
// Description : Round-robin packetizing arbiter sharing one GLIP outbound
//               stream between NUM_CH channels (header word + burst).
//               Optional: GLIP_CHANNEL_ARBITER_PRIORITY_EN gives channel 0
//               strict priority over the round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module glip_channel_arbiter #(
    parameter int WORD_WIDTH = 16,
    parameter int NUM_CH     = 4,
    parameter int MAX_BURST  = 8,
    parameter int CNT_W      = 8
) (
    input  wire logic              clk,
    input  wire logic              rst,
    glip_channel_arbiter_if.master bus
);
    localparam int ID_W  = $clog2(NUM_CH);
    localparam int LEN_W = WORD_WIDTH - ID_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   sel_q, sel_d;
    logic [ID_W-1:0]   last_q, last_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;

    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] req_rr;
    logic              pick_valid;
    logic [ID_W-1:0]   pick_idx;
    logic [CNT_W-1:0]  pick_avail;
    logic [LEN_W-1:0]  pick_len;

    logic [WORD_WIDTH-1:0] sel_data;
    logic                  sel_valid;
    logic [WORD_WIDTH-1:0] hdr_word;

    logic [WORD_WIDTH-1:0] out_data_w;
    logic                  out_valid_w;
    logic [NUM_CH-1:0]     ch_ready_w;
    logic [NUM_CH-1:0]     grant_w;
    logic                  busy_w;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_req
            assign req[i] = |bus.ch_avail[i*CNT_W +: CNT_W];
        end
    endgenerate

    // Channel 0 leaves the rotation when it has strict priority.
`ifdef GLIP_CHANNEL_ARBITER_PRIORITY_EN
    assign req_rr = {req[NUM_CH-1:1], 1'b0};
`else
    assign req_rr = req;
`endif

    // Descending search so the nearest requester after last_q wins.
    always_comb begin
        int              idx;
        logic [ID_W-1:0] idx_w;
        pick_valid = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        idx_w      = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            idx   = (int'(last_q) + k) % NUM_CH;
            idx_w = idx[ID_W-1:0];
            if (req_rr[idx_w]) begin
                pick_valid = 1'b1;
                pick_idx   = idx_w;
            end
        end
`ifdef GLIP_CHANNEL_ARBITER_PRIORITY_EN
        if (req[0]) begin
            pick_valid = 1'b1;
            pick_idx   = '0;
        end
`endif
    end

    always_comb begin
        pick_avail = bus.ch_avail[int'(pick_idx)*CNT_W +: CNT_W];
        if (int'(pick_avail) > MAX_BURST) begin
            pick_len = LEN_W'(MAX_BURST);
        end else begin
            pick_len = LEN_W'(pick_avail);
        end
    end

    assign sel_data  = bus.ch_data[int'(sel_q)*WORD_WIDTH +: WORD_WIDTH];
    assign sel_valid = bus.ch_valid[sel_q];
    assign hdr_word  = {sel_q, len_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            last_q  <= ID_W'(NUM_CH - 1);
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        last_d      = last_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        out_data_w  = '0;
        out_valid_w = 1'b0;
        ch_ready_w  = '0;
        grant_w     = '0;
        busy_w      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    sel_d   = pick_idx;
                    len_d   = pick_len;
                    cnt_d   = pick_len;
                    state_d = ST_HEADER;
                end
            end

            ST_HEADER: begin
                busy_w         = 1'b1;
                grant_w[sel_q] = 1'b1;
                out_valid_w    = 1'b1;
                out_data_w     = hdr_word;
                if (bus.out_ready) begin
                    state_d = ST_DATA;
                end
            end

            ST_DATA: begin
                busy_w            = 1'b1;
                grant_w[sel_q]    = 1'b1;
                out_valid_w       = sel_valid;
                out_data_w        = sel_data;
                ch_ready_w[sel_q] = bus.out_ready;
                // A source bubble holds the counter; no timeout by design.
                if (sel_valid && bus.out_ready) begin
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = ST_IDLE;
                        last_d  = sel_q;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.out_data  = out_data_w;
    assign bus.out_valid = out_valid_w;
    assign bus.ch_ready  = ch_ready_w;
    assign bus.grant     = grant_w;
    assign bus.busy      = busy_w;

endmodule

`default_nettype wire

// File: tb/tb_glip_channel_arbiter.sv
// ============================================================================
// Module      : tb_glip_channel_arbiter
// Description : Scoreboard bench for glip_channel_arbiter with a packet-level
//               reference model of arbitration and framing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_glip_channel_arbiter;
    localparam int WW  = 16;
    localparam int NCH = 4;
    localparam int MB  = 8;
    localparam int CW  = 8;
    localparam int MEM = 8192;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    glip_channel_arbiter_if #(.WORD_WIDTH(WW), .NUM_CH(NCH), .CNT_W(CW)) bus ();

    glip_channel_arbiter #(
        .WORD_WIDTH(WW), .NUM_CH(NCH), .MAX_BURST(MB), .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [WW-1:0] data;
        logic [1:0]    ch;
    } exp_t;

    exp_t          exp_q[$];
    logic [WW-1:0] src_mem [NCH][MEM];
    int            head [NCH];
    int            tail [NCH];
    bit            gate [NCH];

    int vectors    = 0;
    int miscompares = 0;

    int       pending = 0;
    int       m_last  = NCH - 1;
    bit       hdr_due = 1'b0;
    logic [WW-1:0] hdr_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int avail_of(input int ch);
        int n;
        n = tail[ch] - head[ch];
        return (n > 255) ? 255 : n;
    endfunction

    task automatic drive();
        for (int i = 0; i < NCH; i++) begin
            int n;
            n = tail[i] - head[i];
            bus.ch_avail[i*CW +: CW] = CW'(avail_of(i));
            bus.ch_valid[i]          = (n > 0) && gate[i];
            bus.ch_data[i*WW +: WW]  = (n > 0) ? src_mem[i][head[i]] : '0;
        end
    endtask

    task automatic push_word(input int ch, input logic [WW-1:0] w);
        src_mem[ch][tail[ch]] = w;
        tail[ch]++;
    endtask

    // Reference model: decide packets from the bench's own view of the sources.
    always @(negedge clk) begin
        if (!rst) begin
            pending = 0;
            m_last  = NCH - 1;
            hdr_due = 1'b0;
            exp_q.delete();
        end else begin
            if (hdr_due) begin
                check("hdr_latency_valid", 32'(bus.out_valid), 32'd1);
                check("hdr_latency_data", 32'(bus.out_data), 32'(hdr_exp));
                hdr_due = 1'b0;
            end
            if (pending == 0) begin
                int  s;
                int  len;
                bit  found;
                check("idle_busy", 32'(bus.busy), 32'd0);
                check("idle_grant", 32'(bus.grant), 32'd0);
                found = 1'b0;
                s     = 0;
`ifdef GLIP_CHANNEL_ARBITER_PRIORITY_EN
                if (avail_of(0) > 0) begin
                    found = 1'b1;
                    s     = 0;
                end
                for (int k = 1; k <= NCH; k++) begin
                    int c;
                    c = (m_last + k) % NCH;
                    if (!found && c != 0 && avail_of(c) > 0) begin
                        found = 1'b1;
                        s     = c;
                    end
                end
`else
                for (int k = 1; k <= NCH; k++) begin
                    int c;
                    c = (m_last + k) % NCH;
                    if (!found && avail_of(c) > 0) begin
                        found = 1'b1;
                        s     = c;
                    end
                end
`endif
                if (found) begin
                    exp_t e;
                    len     = (avail_of(s) > MB) ? MB : avail_of(s);
                    hdr_exp = {2'(s), 14'(len)};
                    e.ch    = 2'(s);
                    e.data  = hdr_exp;
                    exp_q.push_back(e);
                    for (int j = 0; j < len; j++) begin
                        e.data = src_mem[s][head[s] + j];
                        exp_q.push_back(e);
                    end
                    pending = len + 1;
                    m_last  = s;
                    hdr_due = 1'b1;
                end
            end else if (bus.out_valid && bus.out_ready) begin
                pending--;
            end
        end
    end

    // Monitor: every accepted output word must match the scoreboard head.
    always @(negedge clk) begin
        if (rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", 32'(bus.out_data), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_data", 32'(bus.out_data), 32'(e.data));
                check("grant", 32'(bus.grant), 32'(4'b0001 << e.ch));
                check("busy", 32'(bus.busy), 32'd1);
            end
        end
    end

    int cyc = 0;
    int hs_seen = 0;

    // mode 0 drain, 1 plain, 2 burst-cap stalls, 3 fairness refill, 4 random
    task automatic run_cycles(input int n, input int mode);
        for (int c = 0; c < n; c++) begin
            logic [NCH-1:0] take;
            @(negedge clk);
            take = bus.ch_ready & bus.ch_valid;
            if (bus.out_valid && bus.out_ready) hs_seen++;
            @(posedge clk);
            #1;
            cyc++;
            for (int i = 0; i < NCH; i++) if (take[i]) head[i]++;
            for (int i = 0; i < NCH; i++) gate[i] = 1'b1;
            bus.out_ready = 1'b1;
            case (mode)
                2: begin
                    bus.out_ready = !((cyc % 9) >= 2 && (cyc % 9) <= 6);
                    gate[1]       = !((cyc % 13) >= 5 && (cyc % 13) <= 7);
                end
                3: begin
                    for (int i = 0; i < NCH; i++)
                        if (tail[i] == head[i]) push_word(i, WW'($urandom));
                end
                4: begin
                    for (int i = 0; i < NCH; i++) begin
                        if ((tail[i] - head[i]) < 40 && $urandom_range(3) == 0)
                            push_word(i, WW'($urandom));
                        gate[i] = ($urandom_range(4) != 0);
                    end
                    bus.out_ready = ($urandom_range(3) != 0);
                end
                default: ;
            endcase
            drive();
        end
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 0;
        while ((pending != 0 || exp_q.size() != 0 ||
                tail[0] != head[0] || tail[1] != head[1] ||
                tail[2] != head[2] || tail[3] != head[3]) && budget < 400) begin
            run_cycles(1, 0);
            budget++;
        end
        check(name, 32'(budget < 400), 32'd1);
        run_cycles(2, 0);
    endtask

    initial begin
        for (int i = 0; i < NCH; i++) begin
            head[i] = 0;
            tail[i] = 0;
            gate[i] = 1'b1;
        end
        rst           = 1'b0;
        bus.out_ready = 1'b0;
        drive();
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_ch_ready", 32'(bus.ch_ready), 32'd0);
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b1;

        // Single channel 2 burst of three.
        push_word(2, 16'h00A1);
        push_word(2, 16'h00A2);
        push_word(2, 16'h00A3);
        drive();
        run_cycles(12, 1);
        drain("drain_single");

        // Burst cap with backpressure and source bubbles.
        for (int j = 0; j < 20; j++) push_word(1, WW'(16'h1000 + j));
        drive();
        run_cycles(80, 2);
        drain("drain_cap");

        // Fairness: all channels continuously requesting one word.
        run_cycles(60, 3);
        drain("drain_fair");

        // Randomised traffic.
        run_cycles(2500, 4);
        drain("drain_random");

        // Reset after header plus two of four payload words.
        for (int j = 0; j < 4; j++) push_word(1, WW'(16'h2000 + j));
        drive();
        hs_seen = 0;
        begin
            int budget;
            budget = 0;
            while (hs_seen < 3 && budget < 50) begin
                run_cycles(1, 1);
                budget++;
            end
            check("reset_burst_reached", 32'(hs_seen >= 3), 32'd1);
        end
        rst = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_out_data", 32'(bus.out_data), 32'd0);
        check("mid_rst_ch_ready", 32'(bus.ch_ready), 32'd0);
        check("mid_rst_grant", 32'(bus.grant), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        for (int j = 0; j < 3; j++) begin
            push_word(0, WW'(16'h3000 + j));
            push_word(3, WW'(16'h4000 + j));
        end
        drive();
        run_cycles(2, 1);
        rst = 1'b1;
        drain("drain_after_reset");

        // Channels 0 and 3 both requesting at every decision.
        run_cycles(40, 3);
        drain("drain_final");

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/glip_channel_arbiter.md
# glip_channel_arbiter

Round-robin packetizing arbiter that shares the single GLIP outbound FIFO stream (`fifo_out_*` of the JTAG backend toplevel) between NUM_CH logical requester channels. Each grant emits one header word (channel id + burst length) followed by up to MAX_BURST payload words from the granted channel, so host software can demultiplex. Sits in the `clk` domain between on-chip producers and the backend's `fifo_out_data/valid/ready`.

## Interface
- `WORD_WIDTH`, 16: payload/header word width; equals backend WORD_WIDTH.
- `NUM_CH`, 4: requester channels, 2..16.
- `MAX_BURST`, 8: max payload words per grant, 1..2^(WORD_WIDTH-ID_W)-1; ID_W = clog2(NUM_CH) (localparam).
- `CNT_W`, 8: width of each channel's available-word count.

- `clk` in 1: single clock for all logic.
- `rst` in 1: asynchronous, active-low reset.
- `ch_data` in NUM_CH*WORD_WIDTH: flattened channel words, channel i at [i*WORD_WIDTH +: WORD_WIDTH].
- `ch_valid` in NUM_CH: per-channel word valid.
- `ch_ready` out NUM_CH: per-channel word accepted.
- `ch_avail` in NUM_CH*CNT_W: per-channel count of words the channel guarantees to deliver once granted.
- `out_data` out WORD_WIDTH: to backend `fifo_out_data`.
- `out_valid` out 1: to backend `fifo_out_valid`.
- `out_ready` in 1: from backend `fifo_out_ready`.
- `grant` out NUM_CH: one-hot granted channel, 0 when idle.
- `busy` out 1: high in HEADER or DATA.

## Operation
- States IDLE, HEADER, DATA; reset state IDLE.
- Request of channel i: ch_avail[i] != 0.
- IDLE: if any request, select first requesting channel searching from (last+1) mod NUM_CH upward, wrapping; latch sel, len = min(ch_avail[sel], MAX_BURST), cnt = len; -> HEADER. No request: stay.
- HEADER: out_data = {sel in bits [WORD_WIDTH-1 -: ID_W], zeros, len in low bits}; out_valid=1; on out_ready -> DATA. Header held stable until accepted.
- DATA: out_data = ch_data[sel], out_valid = ch_valid[sel], ch_ready[sel] = out_ready; all other ch_ready 0. Transfer = ch_valid[sel] & out_ready; decrements cnt. Transfer with cnt==1 -> IDLE, last = sel.
- ch_valid[sel] low in DATA: bubble, cnt held; no timeout, no preemption.
- ch_avail sampled only in IDLE; later changes ignored for the current burst.
- Round-robin pointer `last` resets to NUM_CH-1 (channel 0 first).
- Reset values: out_valid 0, out_data 0, ch_ready 0, grant 0, busy 0.

## Timing
- Request visible in IDLE -> header valid next cycle (1-cycle decision latency).
- Header accepted cycle N -> first payload word offered cycle N+1.
- Last payload transfer -> IDLE for one cycle -> next header: exactly one idle cycle between packets; max throughput len/(len+2) words per cycle.
- ch_ready[sel] combinational from out_ready in DATA only; out_valid combinational from ch_valid[sel] in DATA, registered state otherwise.
- Backend full (out_ready=0): everything stalls, state, header and counter held.
- Reset assertion mid-burst: immediate return to IDLE, outputs to reset values, partial packet abandoned; deassertion synchronized externally.

## Configuration
- `GLIP_CHANNEL_ARBITER_PRIORITY_EN` defined: channel 0 has strict priority; in IDLE, channel 0 requesting is always selected, round-robin applies among channels 1..NUM_CH-1 only when channel 0 idle.
- Undefined: pure round-robin over all channels as above.

## Test plan
- Single channel: ch_avail[2]=3, words 0xA1,0xA2,0xA3, out_ready=1 -> out stream 0x8003,0xA1,0xA2,0xA3 (ID 2 in bits 15:14), then out_valid 0.
- Burst cap: ch_avail[1]=20, MAX_BURST=8 -> header 0x4008, 8 words, IDLE, header 0x4008 again only if channel 1 is the sole requester.
- Fairness: all four channels avail=1 continuously -> grant order 0,1,2,3,0,... headers 0x0001,0x4001,0x8001,0xC001.
- Backpressure: out_ready low 5 cycles during header and mid-data -> header/word held stable, no duplicates or drops, cnt unchanged.
- Source bubble: ch_valid[sel] low 3 cycles in DATA -> out_valid low, resumes with next word, total payload equals len.
- Reset mid-burst: rst low after 2 of 4 words -> outputs zero immediately; after release channel 0 granted first. With PRIORITY_EN: ch0 and ch3 requesting every IDLE -> ch0 always granted.
